// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake_fifo slice: counter/pointer sizing and pointer wrap.
// Latency: n/a (compile-time functions and types only).
// Backpressure: n/a.
package handshake_pkg;

  // Selects what drives the downstream port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,  // nothing valid (empty, or flush in progress)
    SRC_MEM    = 2'd1,  // head of the stored queue
    SRC_BYPASS = 2'd2   // upstream word passed straight through an empty buffer
  } out_src_e;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry buffer still needs a one-bit pointer to keep the ports legal.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Advance a pointer, wrapping from depth-1 to 0. The explicit compare (rather than
  // relying on natural overflow) is what makes non-power-of-two depths work.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
    if (ptr >= 32'(depth - 1)) begin
      return '0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_fifo: DEPTH x BITS registers, one write port, async read.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller only asserts we when a word is really stored.
//
// Ports:
//   clock        write clock
//   we/waddr/wdata  write enable, address, data
//   raddr/rdata  combinational read address and data
module handshake_fifo_mem #(
  parameter int BITS     = 8,
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                clock,
  input  logic                we,
  input  logic [PTR_BITS-1:0] waddr,
  input  logic [BITS-1:0]     wdata,
  input  logic [PTR_BITS-1:0] raddr,
  output logic [BITS-1:0]     rdata
);

  // Payload storage is deliberately not reset: the occupancy count, not the
  // contents, decides whether anything here is meaningful.
  logic [BITS-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic valid/ready buffer of DEPTH entries with optional empty-bypass, status and flush.
// Latency: 1 cycle (BYPASS=0); 0 cycles through an empty buffer when BYPASS=1.
// Backpressure: s_ready is registered from next-cycle occupancy; no m_ready->s_ready path.
//
// Ports:
//   clock, reset_n        posedge clock, async active-low reset
//   flush                 synchronous discard of everything stored
//   s_value/s_valid/s_ready   upstream stream
//   m_value/m_valid/m_ready   downstream stream
//   count                 current occupancy (0..DEPTH)
//   almost_full           count >= AFULL
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0,
  parameter int AFULL  = DEPTH - 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [BITS-1:0]            s_value,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [BITS-1:0]            m_value,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [cnt_bits(DEPTH)-1:0] count,
  output logic                       almost_full
);

  localparam int CNT_BITS = cnt_bits(DEPTH);
  localparam int PTR_BITS = ptr_bits(DEPTH);

  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] AFULL_C = CNT_BITS'(AFULL);
  localparam bit                  USE_BYPASS = (BYPASS != 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_next;
  logic                s_ready_q;

  // ---------------------------------------------------------------------------
  // Datapath / handshake signals
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] rd_data;
  out_src_e        out_src;
  logic            empty;
  logic            push;
  logic            pop;
  logic            push_stored;
  logic            pop_stored;
  logic            pass_through;

  assign empty = (count_q == '0);

  // Output source selection. Flush wins so nothing leaves in the discard cycle.
  // In the empty-bypass case the upstream word is only offered downstream when the
  // upstream side is actually transferring it (s_ready high); otherwise a word seen
  // while s_ready is low (just after reset or flush) would be delivered downstream
  // and then presented again by the producer, duplicating it.
  always_comb begin
    out_src = SRC_NONE;
    if (flush) begin
      out_src = SRC_NONE;
    end else if (!empty) begin
      out_src = SRC_MEM;
    end else if (USE_BYPASS && s_valid && s_ready_q) begin
      out_src = SRC_BYPASS;
    end
  end

  // Downstream port. m_value is forced to zero whenever nothing is valid so idle
  // cycles present a clean bus.
  always_comb begin
    m_valid = 1'b0;
    m_value = '0;
    case (out_src)
      SRC_MEM: begin
        m_valid = 1'b1;
        m_value = rd_data;
      end
      SRC_BYPASS: begin
        m_valid = 1'b1;
        m_value = s_value;
      end
      default: begin
        m_valid = 1'b0;
        m_value = '0;
      end
    endcase
  end

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid & m_ready;

  // A bypassed word accepted downstream in the same cycle never touches storage.
  assign pass_through = (out_src == SRC_BYPASS) & m_ready;

  // Flush drops any concurrent push; pop is already blocked because m_valid is 0.
  assign push_stored = push & ~flush & ~pass_through;
  assign pop_stored  = pop & (out_src == SRC_MEM);

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_q + CNT_BITS'(push_stored) - CNT_BITS'(pop_stored);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      count_q <= count_next;
      // Ready reflects room after this edge's updates, so a pop while full
      // re-opens the input one cycle later without any combinational m_ready path.
      s_ready_q <= (count_next < DEPTH_C) & ~flush;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_stored) begin
          wr_ptr <= PTR_BITS'(ptr_inc(32'(wr_ptr), DEPTH));
        end
        if (pop_stored) begin
          rd_ptr <= PTR_BITS'(ptr_inc(32'(rd_ptr), DEPTH));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  handshake_fifo_mem #(
    .BITS     (BITS),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_mem (
    .clock (clock),
    .we    (push_stored),
    .waddr (wr_ptr),
    .wdata (s_value),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign s_ready     = s_ready_q;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_C);

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: three instances (DEPTH=4 registered,
// DEPTH=3 registered, DEPTH=4 bypass) sharing clock and reset.
// Outputs are checked 1 time unit after the posedge, or after a short settle delay.
module tb_handshake_fifo;

  logic clock;
  logic reset_n;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=4, BYPASS=0
  logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_af;
  logic [7:0] a_s_value, a_m_value;
  logic [2:0] a_count;
  // DEPTH=3, BYPASS=0
  logic       b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_af;
  logic [7:0] b_s_value, b_m_value;
  logic [1:0] b_count;
  // DEPTH=4, BYPASS=1
  logic       c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready, c_af;
  logic [7:0] c_s_value, c_m_value;
  logic [2:0] c_count;

  handshake_fifo #(.BITS(8), .DEPTH(4), .BYPASS(0), .AFULL(3)) u_d4 (
    .clock(clock), .reset_n(reset_n), .flush(a_flush),
    .s_value(a_s_value), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_value(a_m_value), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .count(a_count), .almost_full(a_af)
  );

  handshake_fifo #(.BITS(8), .DEPTH(3), .BYPASS(0), .AFULL(2)) u_d3 (
    .clock(clock), .reset_n(reset_n), .flush(b_flush),
    .s_value(b_s_value), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_value(b_m_value), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .count(b_count), .almost_full(b_af)
  );

  handshake_fifo #(.BITS(8), .DEPTH(4), .BYPASS(1), .AFULL(3)) u_bp (
    .clock(clock), .reset_n(reset_n), .flush(c_flush),
    .s_value(c_s_value), .s_valid(c_s_valid), .s_ready(c_s_ready),
    .m_value(c_m_value), .m_valid(c_m_valid), .m_ready(c_m_ready),
    .count(c_count), .almost_full(c_af)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_flush = 0; a_s_valid = 0; a_s_value = '0; a_m_ready = 0;
    b_flush = 0; b_s_valid = 0; b_s_value = '0; b_m_ready = 0;
    c_flush = 0; c_s_valid = 0; c_s_value = '0; c_m_ready = 0;

    // ---------------- reset state ----------------
    #12;
    check("rst_s_ready", a_s_ready, 0);
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_value", a_m_value, 0);
    check("rst_count",   a_count,   0);
    check("rst_afull",   a_af,      0);
    reset_n = 1'b1;
    tick();
    check("rel_s_ready", a_s_ready, 1);
    check("rel_s_ready_d3", b_s_ready, 1);
    check("rel_s_ready_bp", c_s_ready, 1);

    // ---------------- fill DEPTH=4 ----------------
    a_s_valid = 1;
    a_s_value = 8'h11; tick();
    check("fill1_count", a_count, 1); check("fill1_af", a_af, 0);
    check("fill1_m_valid", a_m_valid, 1); check("fill1_m_value", a_m_value, 8'h11);
    a_s_value = 8'h22; tick();
    check("fill2_count", a_count, 2); check("fill2_af", a_af, 0);
    a_s_value = 8'h33; tick();
    check("fill3_count", a_count, 3); check("fill3_af", a_af, 1);
    check("fill3_s_ready", a_s_ready, 1);
    a_s_value = 8'h44; tick();
    check("fill4_count", a_count, 4); check("fill4_af", a_af, 1);
    check("fill4_s_ready", a_s_ready, 0);
    a_s_value = 8'h99; tick();
    check("full_reject_count", a_count, 4);
    check("full_hold_value", a_m_value, 8'h11);
    check("full_hold_valid", a_m_valid, 1);

    // ---------------- drain while streaming ----------------
    a_m_ready = 1; a_s_value = 8'h55; #1;
    check("drain0_value", a_m_value, 8'h11);
    tick();                               // pops 0x11, no push (s_ready was 0)
    check("drain1_count", a_count, 3);
    check("drain1_s_ready", a_s_ready, 1);
    check("drain1_value", a_m_value, 8'h22);
    tick();                               // push 0x55, pop 0x22
    check("drain2_count", a_count, 3);
    check("drain2_value", a_m_value, 8'h33);
    a_s_value = 8'h66; tick();            // push 0x66, pop 0x33
    check("drain3_value", a_m_value, 8'h44);
    a_s_valid = 0; tick();                // pop 0x44
    check("drain4_count", a_count, 2);
    check("drain4_value", a_m_value, 8'h55);
    tick();
    check("drain5_value", a_m_value, 8'h66);
    tick();
    check("drain6_count", a_count, 0);
    check("drain6_m_valid", a_m_valid, 0);
    check("drain6_m_value", a_m_value, 0);
    tick();                               // empty with m_ready high: no underflow
    check("underflow_count", a_count, 0);
    check("underflow_s_ready", a_s_ready, 1);
    a_m_ready = 0;

    // ---------------- DEPTH=3 streaming, pointer wrap ----------------
    b_s_valid = 1; b_m_ready = 1;
    for (int k = 0; k < 10; k++) begin
      b_s_value = 8'(k + 1);
      #1;
      check("d3_m_valid", b_m_valid, (k > 0) ? 1 : 0);
      if (k > 0) check("d3_m_value", b_m_value, k);
      check("d3_s_ready", b_s_ready, 1);
      tick();
      check("d3_count", b_count, 1);
    end
    b_s_valid = 0; #1;
    check("d3_last_value", b_m_value, 10);
    tick();
    check("d3_final_count", b_count, 0);
    check("d3_final_m_valid", b_m_valid, 0);
    b_m_ready = 0;

    // ---------------- bypass ----------------
    c_s_valid = 1; c_s_value = 8'hA5; c_m_ready = 1; #1;
    check("bp_pass_valid", c_m_valid, 1);
    check("bp_pass_value", c_m_value, 8'hA5);
    tick();
    check("bp_pass_count", c_count, 0);
    c_m_ready = 0; #1;
    check("bp_stall_valid", c_m_valid, 1);
    check("bp_stall_value", c_m_value, 8'hA5);
    tick();
    check("bp_store_count", c_count, 1);
    c_s_valid = 0; c_s_value = 8'h00; #1;
    check("bp_held_value", c_m_value, 8'hA5);
    tick();
    check("bp_held2_value", c_m_value, 8'hA5);
    check("bp_held2_valid", c_m_valid, 1);
    c_m_ready = 1; tick();
    check("bp_drain_count", c_count, 0);
    check("bp_drain_valid", c_m_valid, 0);
    c_m_ready = 0;

    // ---------------- flush ----------------
    a_s_valid = 1; a_s_value = 8'hB1; tick();
    a_s_value = 8'hB2; tick();
    check("fl_pre_count", a_count, 2);
    a_flush = 1; a_s_value = 8'hEE; a_m_ready = 1; #1;
    check("fl_cycle_m_valid", a_m_valid, 0);
    tick();
    a_flush = 0; a_s_valid = 0; a_m_ready = 0; #1;
    check("fl_count", a_count, 0);
    check("fl_m_valid", a_m_valid, 0);
    check("fl_s_ready", a_s_ready, 0);
    tick();
    check("fl_s_ready_back", a_s_ready, 1);
    check("fl_post_count", a_count, 0);
    check("fl_post_m_valid", a_m_valid, 0);
    a_s_valid = 1; a_s_value = 8'hC3; tick();
    a_s_valid = 0;
    check("fl_new_value", a_m_value, 8'hC3);
    check("fl_new_count", a_count, 1);
    a_m_ready = 1; tick();
    check("fl_drain_count", a_count, 0);
    a_m_ready = 0;

    // ---------------- async reset mid-operation ----------------
    a_s_valid = 1;
    a_s_value = 8'h01; tick();
    a_s_value = 8'h02; tick();
    a_s_value = 8'h03; tick();
    a_s_valid = 0;
    check("ar_pre_count", a_count, 3);
    #2 reset_n = 1'b0;
    #1;
    check("ar_count", a_count, 0);
    check("ar_m_valid", a_m_valid, 0);
    check("ar_s_ready", a_s_ready, 0);
    check("ar_afull", a_af, 0);
    #2 reset_n = 1'b1;
    tick();
    check("ar_rel_s_ready", a_s_ready, 1);
    check("ar_rel_count", a_count, 0);
    check("ar_rel_m_valid", a_m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
